// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC owner, fetch queue, redirect/flush, end-of-program drain to halt.
// First instruction valid two cycles after start; a full queue with inst_ready low stalls the PC.
module fetch_sequencer #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] END_PC   = 32'h0000_0040
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] mem_pc,
    input  logic [31:0] mem_instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        busy,
    output logic        halted,
    output logic        align_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } entry_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    entry_t        fifo_q [DEPTH];
    entry_t        fifo_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          align_err_q, align_err_d;

    logic          redirect_take;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_tgt;
    entry_t        head;

    assign head       = fifo_q[rd_ptr_q];
    assign inst_valid = (count_q != '0);
    assign inst_out   = inst_valid ? head.ins : 32'h0;
    assign inst_pc    = inst_valid ? head.pc  : 32'h0;
    assign mem_pc     = fetch_pc_q;
    assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign halted     = (state_q == ST_HALTED);
    assign align_err  = align_err_q;

    always_comb begin
        redirect_tgt  = {redirect_pc[31:2], 2'b00};
        redirect_take = redirect_valid && busy;
        pop           = inst_valid && inst_ready;
        // A pop this cycle frees a slot, so a full queue can still accept a fetch.
        push          = (state_q == ST_RUN) && !redirect_take && (fetch_pc_q != END_PC)
                        && ((count_q != DEPTH_C) || pop);
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        align_err_d = 1'b0;

        if (push) begin
            fifo_d[wr_ptr_q] = '{pc: fetch_pc_q, ins: mem_instruction};
            wr_ptr_d         = wr_ptr_q + PW'(1);
            fetch_pc_d       = fetch_pc_q + 32'd4;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // The head handshake above still counts; everything left behind is dropped.
        if (redirect_take) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            fetch_pc_d  = redirect_tgt;
            align_err_d = (redirect_pc[1:0] != 2'b00);
        end

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_d    = ST_RUN;
                    fetch_pc_d = RESET_PC;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    count_d    = '0;
                end
            end
            ST_RUN: begin
                if (redirect_take) begin
                    state_d = (redirect_tgt == END_PC) ? ST_DRAIN : ST_RUN;
                end else if (fetch_pc_d == END_PC) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (redirect_take) begin
                    state_d = (redirect_tgt == END_PC) ? ST_DRAIN : ST_RUN;
                end else if (count_d == '0) begin
                    state_d = ST_HALTED;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= RESET_PC;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            align_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            align_err_q <= align_err_d;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && !pop && (count_q == DEPTH_C)));
            assert (!(pop && (count_q == '0)));
        end
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the 256-word instruction memory.
- Owns the program counter and drives the memory address each cycle.
- Captures returned 32-bit instructions into a small fetch queue and hands them to decode over a valid/ready handshake.
- Handles start, jump redirect with queue flush, and end-of-program drain/halt.

Parameters:
- DEPTH, 2, fetch queue entries; power of 2, minimum 2.
- RESET_PC, 32'h0000_0000, PC loaded on reset and on start; word aligned.
- END_PC, 32'h0000_0040, exclusive fetch limit (16 words); fetching stops when fetch_pc == END_PC.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin fetching from RESET_PC; honoured in IDLE and HALTED only.
- mem_pc  out  32  byte address to instruction memory (memory indexes pc>>2).
- mem_instruction  in  32  instruction returned by memory, combinational from mem_pc.
- redirect_valid  in  1  jump request, single-cycle strobe.
- redirect_pc  in  32  jump target byte address.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode accepts head.
- inst_out  out  32  head instruction {op[31:29], imm[28], rd[27:23], rs1[22:18], rs2/imm[17:0]}.
- inst_pc  out  32  byte address of head instruction.
- busy  out  1  state is RUN or DRAIN.
- halted  out  1  state is HALTED.
- align_err  out  1  one-cycle pulse: misaligned redirect_pc was received.

Behaviour:
- Reset (async assert, sync release): state=IDLE, fetch_pc=RESET_PC, queue empty (inst_valid=0, inst_out=0, inst_pc=0), busy=0, halted=0, align_err=0.
- mem_pc = fetch_pc, registered; it is never driven from combinational inputs.
- States and transitions:
  - IDLE: start -> RUN.
  - RUN: fetch_pc reaches END_PC -> DRAIN.
  - DRAIN: queue empty -> HALTED; redirect -> RUN.
  - HALTED: start -> RUN, with fetch_pc=RESET_PC and queue empty.
  - redirect_valid is ignored in IDLE and HALTED.
- Push: in RUN, if fetch_pc != END_PC and (count < DEPTH or a pop occurs this cycle), write {fetch_pc, mem_instruction} to the tail and set fetch_pc += 4. Otherwise fetch_pc holds (stall).
- Pop: inst_valid & inst_ready removes the head. Push and pop in the same cycle leave count unchanged.
- Throughput: one instruction per cycle while inst_ready=1.
- Latency: start sampled at edge N -> mem_pc=RESET_PC during cycle N+1 -> inst_valid=1 with inst_pc=RESET_PC in cycle N+2.
- inst_out and inst_pc are held stable while inst_valid=1 and inst_ready=0.
- Redirect (RUN or DRAIN) has priority over push:
  - The current head handshake, if it occurs, still completes.
  - All remaining entries and this cycle's push are discarded; queue empty next cycle.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - State -> RUN, or DRAIN if the aligned target == END_PC.
- Misalignment: redirect_pc[1:0] != 0 -> target aligned down, align_err=1 for the next cycle.
- Redirect target >= END_PC is accepted. Fetch then runs until fetch_pc == END_PC, wrapping at 2^32; no 256-word bound check.
- Simultaneous start and redirect in HALTED: start wins.
- count ranges 0..DEPTH. Pointers wrap modulo DEPTH. Overflow and underflow are impossible by construction; assert in simulation.
- Reset asserted mid-operation: immediate return to reset values and the queue is discarded.

Test Plan:
- Reset then start, inst_ready=1 throughout -> inst_pc 0x00,0x04,...,0x3C on 16 consecutive cycles; first valid 2 cycles after start; busy low and halted high one cycle after last pop.
- start with inst_ready=0 -> fetch stalls with DEPTH=2 entries (inst_pc 0x00, 0x04) and mem_pc held at 0x08; inst_out stable. Raise inst_ready -> in-order delivery, no loss or duplication.
- Redirect to 0x20 while queue holds 0x08,0x0C and head is accepted that cycle -> 0x08 delivered; 0x0C dropped; next valid inst_pc=0x20 two cycles later.
- redirect_pc=0x15 -> align_err pulses once; next delivered inst_pc=0x14.
- Redirect during DRAIN to 0x00 -> returns to RUN, refetches 0x00..0x3C, halts again. start in HALTED -> restarts at RESET_PC.
- rst_n low mid-stream with 2 entries queued -> inst_valid=0 and mem_pc=RESET_PC immediately, without waiting for a clock edge; state IDLE.
